// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants for the multiply/divide sequencer: state encoding,
// instruction decode values and the exception writeback target.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } md_state_e;

  localparam logic [4:0] OP_RTYPE    = 5'b00000;
  localparam logic [4:0] ALU_MUL     = 5'b00110;
  localparam logic [4:0] ALU_DIV     = 5'b00111;
  localparam logic [4:0] RSTATUS_REG = 5'd30;

  localparam int TIMEOUT_DEF      = 40;
  localparam int MUL_EXC_CODE_DEF = 4;
  localparam int DIV_EXC_CODE_DEF = 5;

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating 6-bit WAIT-cycle counter with a terminal-count flag at TIMEOUT-1.
module md_timeout_counter #(
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [5:0] count_q;
  logic [5:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != 6'h3f)) begin
      count_d = count_q + 6'd1;
    end
  end

  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == 6'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative mul/div unit: launches it, freezes the
// PC while it runs, then overrides the register-file writeback for one cycle.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int TIMEOUT      = TIMEOUT_DEF,
  parameter int MUL_EXC_CODE = MUL_EXC_CODE_DEF,
  parameter int DIV_EXC_CODE = DIV_EXC_CODE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [4:0]  opcode,
  input  logic [4:0]  aluOp,
  input  logic [4:0]  rd,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        busy
);

  md_state_e   state_q, state_d;
  logic        is_div_q, is_div_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic is_mul, is_div, is_md;
  logic cnt_clear, cnt_en, cnt_term;

  assign is_mul = (opcode == OP_RTYPE) && (aluOp == ALU_MUL);
  assign is_div = (opcode == OP_RTYPE) && (aluOp == ALU_DIV);
  // Gated by reset so nothing, not even the issue-cycle stall, escapes while held in reset.
  assign is_md  = reset && instr_valid && (is_mul || is_div);

  md_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_term)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    rd_d      = rd_q;
    result_d  = result_q;
    exc_d     = exc_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (is_md) begin
          is_div_d = is_div;
          rd_d     = rd;
          result_d = '0;
          exc_d    = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        // md_resultRDY may still reflect the previous operation here.
        cnt_clear = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_en = 1'b1;
        if (md_resultRDY) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = ST_WB;
        end else if (cnt_term) begin
          exc_d   = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the result/rd holding registers are reset along with the FSM; they
  // are few and clearing them keeps post-reset outputs fully defined.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      rd_q     <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    ctrl_MULT = (state_q == ST_START) && !is_div_q;
    ctrl_DIV  = (state_q == ST_START) && is_div_q;
    stall     = ((state_q == ST_IDLE) && is_md) || (state_q == ST_START) || (state_q == ST_WAIT);
    busy      = (state_q != ST_IDLE);
    wb_en     = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    if (state_q == ST_WB) begin
      if (exc_q) begin
        wb_en   = 1'b1;
        wb_reg  = RSTATUS_REG;
        wb_data = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
      end else begin
        // r0 is hardwired; the sequence completes without a write.
        wb_en   = (rd_q != 5'd0);
        wb_reg  = rd_q;
        wb_data = result_q;
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
module tb_multdiv_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [4:0]  opcode;
  logic [4:0]  aluOp;
  logic [4:0]  rd;
  logic        md_resultRDY;
  logic        md_exception;
  logic [31:0] md_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        busy;

  int checks;
  int failures;

  multdiv_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .opcode       (opcode),
    .aluOp        (aluOp),
    .rd           (rd),
    .md_resultRDY (md_resultRDY),
    .md_exception (md_exception),
    .md_result    (md_result),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .stall        (stall),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Flags packed as {ctrl_MULT, ctrl_DIV, stall, wb_en, busy}.
  wire [4:0] flags = {ctrl_MULT, ctrl_DIV, stall, wb_en, busy};

  task automatic test_reset();
    reset        = 1'b0;
    instr_valid  = 1'b0;
    opcode       = '0;
    aluOp        = '0;
    rd           = '0;
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
    md_result    = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (flags !== 5'b00000 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: flags=%b wb_reg=%0d wb_data=%h, required flags=00000 wb_reg=0 wb_data=0",
               flags, wb_reg, wb_data);
    end
    reset = 1'b1;
  endtask

  // Issues one mul/div at the current negedge (FSM in IDLE) and follows it to IDLE.
  // rdy_at: WAIT cycle (1-based) in which md_resultRDY is high; 0 means never.
  task automatic run_op(input string name, input logic div, input logic [4:0] dst,
                        input int rdy_at, input logic exc, input logic [31:0] res,
                        input logic exp_en, input logic [4:0] exp_reg,
                        input logic [31:0] exp_data);
    int waits;
    int exp_waits;
    logic [4:0] exp_start;
    exp_waits = (rdy_at > 0) ? rdy_at : TIMEOUT;
    exp_start = div ? 5'b01101 : 5'b10101;

    instr_valid = 1'b1;
    opcode      = 5'b00000;
    aluOp       = div ? 5'b00111 : 5'b00110;
    rd          = dst;
    #1;
    checks++;
    if (flags !== 5'b00100) begin
      failures++;
      $display("FAIL %s_issue: flags=%b required=00100", name, flags);
    end

    @(negedge clock);
    instr_valid  = 1'b0;
    md_resultRDY = 1'b1;  // stale ready during START must be ignored
    md_exception = 1'b1;
    #1;
    checks++;
    if (flags !== exp_start) begin
      failures++;
      $display("FAIL %s_start: flags=%b required=%b", name, flags, exp_start);
    end

    waits = 0;
    for (int k = 1; k <= TIMEOUT + 20; k++) begin
      @(negedge clock);
      md_resultRDY = (k == rdy_at);
      md_exception = (k == rdy_at) ? exc : 1'b1;  // exception unqualified when not ready
      md_result    = (k == rdy_at) ? res : 32'hBAD0BAD0;
      #1;
      if (!stall) break;
      waits++;
      checks++;
      if (flags !== 5'b00101) begin
        failures++;
        $display("FAIL %s_wait%0d: flags=%b required=00101", name, k, flags);
      end
    end
    md_resultRDY = 1'b0;
    md_exception = 1'b0;

    checks++;
    if (waits !== exp_waits) begin
      failures++;
      $display("FAIL %s_wait_count: waits=%0d required=%0d", name, waits, exp_waits);
    end

    checks++;
    if (flags !== {3'b000, exp_en, 1'b1}) begin
      failures++;
      $display("FAIL %s_wb_flags: flags=%b required=%b", name, flags, {3'b000, exp_en, 1'b1});
    end
    if (exp_en) begin
      checks++;
      if (wb_reg !== exp_reg || wb_data !== exp_data) begin
        failures++;
        $display("FAIL %s_wb_value: wb_reg=%0d wb_data=%h required wb_reg=%0d wb_data=%h",
                 name, wb_reg, wb_data, exp_reg, exp_data);
      end
    end

    @(negedge clock);
    #1;
    checks++;
    if (flags !== 5'b00000 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL %s_idle: flags=%b wb_reg=%0d wb_data=%h required all zero",
               name, flags, wb_reg, wb_data);
    end
  endtask

  task automatic test_mul();
    run_op("mul", 1'b0, 5'd5, 33, 1'b0, 32'h00000F00, 1'b1, 5'd5, 32'h00000F00);
  endtask

  task automatic test_div();
    run_op("div", 1'b1, 5'd12, 1, 1'b0, 32'hDEADBEEF, 1'b1, 5'd12, 32'hDEADBEEF);
  endtask

  task automatic test_div_exception();
    run_op("div_exc", 1'b1, 5'd7, 10, 1'b1, 32'h00001234, 1'b1, 5'd30, 32'd5);
  endtask

  task automatic test_timeout();
    run_op("timeout", 1'b0, 5'd9, 0, 1'b0, 32'd0, 1'b1, 5'd30, 32'd4);
  endtask

  task automatic test_rd_zero();
    run_op("rd_zero", 1'b0, 5'd0, 5, 1'b0, 32'h0000ABCD, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 1'b0, 5'd3, 4, 1'b0, 32'h11111111, 1'b1, 5'd3, 32'h11111111);
    run_op("b2b_second", 1'b0, 5'd4, 2, 1'b0, 32'h22222222, 1'b1, 5'd4, 32'h22222222);
  endtask

  task automatic test_non_md();
    logic [4:0] ops [3];
    logic [4:0] alus [3];
    logic       vals [3];
    ops[0] = 5'b00000; alus[0] = 5'b00000; vals[0] = 1'b1;  // add
    ops[1] = 5'b00000; alus[1] = 5'b00110; vals[1] = 1'b0;  // mul bubble
    ops[2] = 5'b00101; alus[2] = 5'b00111; vals[2] = 1'b1;  // non R-type
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      instr_valid = vals[i];
      opcode      = ops[i];
      aluOp       = alus[i];
      rd          = 5'd8;
      #1;
      checks++;
      if (flags !== 5'b00000) begin
        failures++;
        $display("FAIL non_md_%0d_now: flags=%b required=00000", i, flags);
      end
      @(negedge clock);
      #1;
      checks++;
      if (flags !== 5'b00000) begin
        failures++;
        $display("FAIL non_md_%0d_next: flags=%b required=00000", i, flags);
      end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clock);
    instr_valid = 1'b1;
    opcode      = 5'b00000;
    aluOp       = 5'b00110;
    rd          = 5'd6;
    @(negedge clock);
    instr_valid = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    checks++;
    if (flags !== 5'b00101) begin
      failures++;
      $display("FAIL rst_pre_wait: flags=%b required=00101", flags);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (flags !== 5'b00000 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin
      failures++;
      $display("FAIL rst_immediate: flags=%b wb_reg=%0d wb_data=%h required all zero",
               flags, wb_reg, wb_data);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      md_resultRDY = (k == 1);
      md_exception = (k == 1);
      md_result    = 32'hCAFEF00D;
      #1;
      checks++;
      if (flags !== 5'b00000) begin
        failures++;
        $display("FAIL rst_after_%0d: flags=%b required=00000", k, flags);
      end
      @(negedge clock);
    end
    md_resultRDY = 1'b0;
    md_exception = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_exception();
    test_timeout();
    test_rd_zero();
    test_back_to_back();
    test_non_md();
    test_reset_mid_wait();
    @(negedge clock);
    run_op("post_reset", 1'b1, 5'd2, 3, 1'b0, 32'h0000BEEF, 1'b1, 5'd2, 32'h0000BEEF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
